// File: rtl/sum_block_accumulator.sv
// Accumulates BLOCK_LEN consecutive adder-stage sums and equality flags into one block
// result, then holds the result on a valid/ready output until downstream takes it.
module sum_block_accumulator #(
    parameter int DATA_W    = 17,
    parameter int ACC_W     = 24,
    parameter int BLOCK_LEN = 4,
    localparam int CNT_W    = $clog2(BLOCK_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_is_eq,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_eq_count,
    output logic              out_overflow,
    output logic [1:0]        o_dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // the producer must keep its data stable until that edge.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN);

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_eq_cnt;
    logic               r_ovf;
    logic [ACC_W-1:0]   r_out_sum;
    logic [CNT_W-1:0]   r_out_eq;
    logic               r_out_ovf;

    state_t             w_state_nxt;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_eq_nxt;
    logic               w_ovf_nxt;
    logic               w_load_out;
    logic               w_accept;
    logic [ACC_W-1:0]   w_ext;
    logic [CNT_W-1:0]   w_eq_inc;
    logic [ACC_W:0]     w_sum;

    assign in_ready  = (r_state != HOLD);
    assign w_accept  = in_valid && in_ready;
    assign w_sum     = {1'b0, r_acc} + {1'b0, w_ext};

    always_comb begin
        w_ext              = '0;
        w_ext[DATA_W-1:0]  = in_data;
        w_eq_inc           = '0;
        w_eq_inc[0]        = in_is_eq;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_eq_cnt  <= '0;
            r_ovf     <= 1'b0;
            r_out_sum <= '0;
            r_out_eq  <= '0;
            r_out_ovf <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_eq_cnt <= w_eq_nxt;
            r_ovf    <= w_ovf_nxt;
            if (w_load_out) begin
                r_out_sum <= w_acc_nxt;
                r_out_eq  <= w_eq_nxt;
                r_out_ovf <= w_ovf_nxt;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_eq_nxt    = r_eq_cnt;
        w_ovf_nxt   = r_ovf;
        w_load_out  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_acc_nxt = w_ext;
                    w_eq_nxt  = w_eq_inc;
                    w_cnt_nxt = CNT_ONE;
                    w_ovf_nxt = 1'b0;
                    if (CNT_ONE == CNT_LAST) begin
                        w_state_nxt = HOLD;
                        w_load_out  = 1'b1;
                    end else begin
                        w_state_nxt = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (w_accept) begin
                    w_acc_nxt = w_sum[ACC_W-1:0];
                    w_ovf_nxt = r_ovf | w_sum[ACC_W];
                    w_eq_nxt  = r_eq_cnt + w_eq_inc;
                    w_cnt_nxt = r_cnt + CNT_ONE;
                    if (w_cnt_nxt == CNT_LAST) begin
                        w_state_nxt = HOLD;
                        w_load_out  = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Result registers are loaded only at block completion, so they keep the last block between blocks.
    assign out_valid    = (r_state == HOLD);
    assign out_sum      = r_out_sum;
    assign out_eq_count = r_out_eq;
    assign out_overflow = r_out_ovf;
    assign o_dbg_state  = r_state;

endmodule
